// File: rtl/flatten_streamer.sv
// flatten_streamer: reads NUM_WORDS layer-1 words in flatten (row-major)
// order and streams them out through a small credit-controlled FIFO,
// tracking the running unsigned maximum of the streamed words.
//
// state  | meaning
// IDLE   | waiting for start; max_val holds the last run's result
// READ   | issuing reads 0..NUM_WORDS-1 while FIFO credits allow
// DRAIN  | all reads issued; emptying FIFO until the last beat
// FINISH | one-cycle done pulse, then back to IDLE
module flatten_streamer #(
  parameter int         NUM_WORDS  = 1024,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [2:0] L1_SEL     = 3'b011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        crd,
  output logic [11:0] caddr_rd,
  output logic [2:0]  csel,
  input  logic [19:0] cdata_rd,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [19:0] m_data,
  output logic        m_last,
  output logic        done,
  output logic [19:0] max_val
);

  localparam int AW = $clog2(NUM_WORDS + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_WORDS - 1);
  localparam logic [CW:0]   DEPTH_V  = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;
  state_t state_q, state_d;

  logic [AW-1:0] addr_q;
  logic [AW-1:0] beat_q;
  logic          inflight_q;
  logic [19:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [19:0]   max_q;
  logic          start_ok;
  logic          credit_ok;
  logic          push;
  logic          pop;

  assign start_ok  = (state_q == IDLE) && start;
  // Count the read in flight against the FIFO so its data always has a slot.
  assign credit_ok = ({1'b0, cnt_q} + {{CW{1'b0}}, inflight_q}) < DEPTH_V;
  assign push      = inflight_q;
  assign pop       = m_valid && m_ready;

  assign caddr_rd = 12'(addr_q);
  assign csel     = crd ? L1_SEL : 3'b000;
  assign m_valid  = (cnt_q != '0);
  assign m_data   = fifo_mem[rd_ptr_q];
  // Last flag comes from the beat count so it follows the consumer side.
  assign m_last   = m_valid && (beat_q == LAST_IDX);
  assign max_val  = max_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode plus read strobe, busy and done.
  always_comb begin
    state_d = state_q;
    crd     = 1'b0;
    done    = 1'b0;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE:   if (start) state_d = READ;
      READ: begin
        if (credit_ok) begin
          crd = 1'b1;
          if (addr_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN:  if (pop && m_last) state_d = FINISH;
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address and beat counters, cleared when a run is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      beat_q <= '0;
    end else if (start_ok) begin
      addr_q <= '0;
      beat_q <= '0;
    end else begin
      if (crd) addr_q <= addr_q + AW'(1);
      if (pop) beat_q <= beat_q + AW'(1);
    end
  end

  // One-cycle read latency tracker; cleared by reset so stale data is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) inflight_q <= 1'b0;
    else       inflight_q <= crd;
  end

  // Output FIFO: returned read data is pushed on the edge it is sampled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_q] <= cdata_rd;
        wr_ptr_q           <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Running unsigned maximum of transferred beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     max_q <= '0;
    else if (start_ok)             max_q <= '0;
    else if (pop && m_data > max_q) max_q <= m_data;
  end

endmodule

// File: tb/tb_flatten_streamer.sv
// Bench for flatten_streamer: synchronous memory model, random backpressure,
// and a scoreboard that expects mem[0..N-1] in order.
module tb_flatten_streamer;

  localparam int N = 1024;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [2:0]  csel;
  logic [19:0] cdata_rd;
  logic        m_valid;
  logic        m_ready;
  logic [19:0] m_data;
  logic        m_last;
  logic        done;
  logic [19:0] max_val;

  int n_checks = 0;
  int n_fail   = 0;

  flatten_streamer #(.NUM_WORDS(N), .FIFO_DEPTH(4), .L1_SEL(3'b011)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .crd(crd),
    .caddr_rd(caddr_rd), .csel(csel), .cdata_rd(cdata_rd),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .done(done), .max_val(max_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data appears the cycle after the read strobe.
  logic [19:0] mem [0:4095];
  initial cdata_rd = '0;
  always @(posedge clk) if (crd) cdata_rd <= mem[caddr_rd];

  // Ready driver: 0 = held low, 1 = held high, 2 = random 50%.
  int ready_mode = 0;
  initial m_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Passive monitor: collects beats and counts protocol anomalies.
  int          cyc = 0;
  int          issued = 0;
  int          accepted = 0;
  logic [19:0] got_q [$];
  bit          got_last_q [$];
  int          first_beat_cyc = 0;
  int          last_beat_cyc = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;
  int          addr_bad = 0;
  int          csel_bad = 0;
  int          crd_viol = 0;
  int          stab_bad = 0;
  logic        prev_stall = 1'b0;
  logic [19:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      issued = 0;
      accepted = 0;
      got_q.delete();
      got_last_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (start && !busy) begin
        issued = 0;
        accepted = 0;
        got_q.delete();
        got_last_q.delete();
      end
      if (crd ? (csel !== 3'b011) : (csel !== 3'b000)) csel_bad++;
      if (crd) begin
        if (caddr_rd !== 12'(issued)) addr_bad++;
        if (issued - accepted >= 4) crd_viol++;
      end
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stab_bad++;
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        got_last_q.push_back(m_last);
        if (accepted == 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        accepted++;
      end
      if (crd) issued++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [19:0] model_max();
    logic [19:0] m = '0;
    for (int i = 0; i < N; i++) if (mem[i] > m) m = mem[i];
    return m;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %0b exp 0", busy); end
    n_checks++; if (crd !== 1'b0)      begin n_fail++; $display("FAIL reset_crd got %0b exp 0", crd); end
    n_checks++; if (caddr_rd !== 12'd0) begin n_fail++; $display("FAIL reset_caddr got %0d exp 0", caddr_rd); end
    n_checks++; if (csel !== 3'd0)     begin n_fail++; $display("FAIL reset_csel got %0d exp 0", csel); end
    n_checks++; if (m_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_m_valid got %0b exp 0", m_valid); end
    n_checks++; if (m_last !== 1'b0)   begin n_fail++; $display("FAIL reset_m_last got %0b exp 0", m_last); end
    n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done got %0b exp 0", done); end
    n_checks++; if (max_val !== 20'd0) begin n_fail++; $display("FAIL reset_max got %0h exp 0", max_val); end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0 || crd !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset busy=%0b crd=%0b exp 0 0", busy, crd); end
  endtask

  task automatic test_full_run();
    bit to;
    int lat;
    int errs;
    int done0;
    int ab0;
    int cs0;
    for (int i = 0; i < N; i++) mem[i] = 20'(i);
    ready_mode = 1;
    done0 = done_cnt; ab0 = addr_bad; cs0 = csel_bad;
    pulse_start();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy got %0b exp 1", busy); end
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_valid) break;
      lat++;
    end
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL full_latency got %0d exp 3", lat); end
    wait_done(3000, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL full_done_timeout got timeout exp done"); end
    errs = 0;
    for (int i = 0; i < N; i++)
      if (i >= got_q.size() || got_q[i] !== mem[i] || got_last_q[i] !== (i == N-1)) errs++;
    n_checks++; if (got_q.size() != N) begin n_fail++; $display("FAIL full_beats got %0d exp %0d", got_q.size(), N); end
    n_checks++; if (errs != 0) begin n_fail++; $display("FAIL full_sequence got %0d bad beats exp 0", errs); end
    n_checks++; if (max_val !== model_max()) begin n_fail++; $display("FAIL full_max got %0h exp %0h", max_val, model_max()); end
    n_checks++; if (done_cyc != last_beat_cyc + 1) begin n_fail++; $display("FAIL full_done_timing got %0d exp %0d", done_cyc, last_beat_cyc + 1); end
    n_checks++; if (last_beat_cyc - first_beat_cyc != N-1) begin n_fail++; $display("FAIL full_throughput got span %0d exp %0d", last_beat_cyc - first_beat_cyc, N-1); end
    n_checks++; if (done_cnt - done0 != 1) begin n_fail++; $display("FAIL full_done_count got %0d exp 1", done_cnt - done0); end
    n_checks++; if (addr_bad != ab0) begin n_fail++; $display("FAIL full_addr_order got %0d bad exp 0", addr_bad - ab0); end
    n_checks++; if (csel_bad != cs0) begin n_fail++; $display("FAIL full_csel got %0d bad exp 0", csel_bad - cs0); end
  endtask

  task automatic test_backpressure();
    bit to;
    int errs;
    int cv0;
    int sb0;
    int ab0;
    for (int i = 0; i < N; i++) mem[i] = 20'($urandom);
    ready_mode = 2;
    cv0 = crd_viol; sb0 = stab_bad; ab0 = addr_bad;
    pulse_start();
    wait_done(6000, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL bp_done_timeout got timeout exp done"); end
    errs = 0;
    for (int i = 0; i < N; i++)
      if (i >= got_q.size() || got_q[i] !== mem[i] || got_last_q[i] !== (i == N-1)) errs++;
    n_checks++; if (got_q.size() != N) begin n_fail++; $display("FAIL bp_beats got %0d exp %0d", got_q.size(), N); end
    n_checks++; if (errs != 0) begin n_fail++; $display("FAIL bp_sequence got %0d bad beats exp 0", errs); end
    n_checks++; if (crd_viol != cv0) begin n_fail++; $display("FAIL bp_credit got %0d overissues exp 0", crd_viol - cv0); end
    n_checks++; if (stab_bad != sb0) begin n_fail++; $display("FAIL bp_stability got %0d unstable exp 0", stab_bad - sb0); end
    n_checks++; if (addr_bad != ab0) begin n_fail++; $display("FAIL bp_addr_order got %0d bad exp 0", addr_bad - ab0); end
    n_checks++; if (max_val !== model_max()) begin n_fail++; $display("FAIL bp_max got %0h exp %0h", max_val, model_max()); end
  endtask

  task automatic test_stall();
    bit to;
    int errs;
    for (int i = 0; i < N; i++) mem[i] = 20'(i);
    ready_mode = 0;
    repeat (2) @(posedge clk);
    pulse_start();
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (issued != 4) begin n_fail++; $display("FAIL stall_reads got %0d exp 4", issued); end
    n_checks++; if (crd !== 1'b0) begin n_fail++; $display("FAIL stall_crd got %0b exp 0", crd); end
    n_checks++; if (m_valid !== 1'b1 || m_data !== 20'd0) begin n_fail++; $display("FAIL stall_head got v=%0b d=%0h exp v=1 d=0", m_valid, m_data); end
    ready_mode = 1;
    wait_done(3000, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL stall_done_timeout got timeout exp done"); end
    errs = 0;
    for (int i = 0; i < N; i++)
      if (i >= got_q.size() || got_q[i] !== mem[i] || got_last_q[i] !== (i == N-1)) errs++;
    n_checks++; if (got_q.size() != N || errs != 0) begin n_fail++; $display("FAIL stall_sequence got %0d beats %0d bad exp %0d beats 0 bad", got_q.size(), errs, N); end
  endtask

  task automatic test_max();
    bit to;
    for (int i = 0; i < N; i++) mem[i] = 20'd0;
    mem[517] = 20'hFFFFF;
    ready_mode = 2;
    pulse_start();
    #2;
    n_checks++; if (max_val !== 20'd0) begin n_fail++; $display("FAIL max_clear got %0h exp 0", max_val); end
    wait_done(6000, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL max_done_timeout got timeout exp done"); end
    n_checks++; if (max_val !== model_max()) begin n_fail++; $display("FAIL max_value got %0h exp %0h", max_val, model_max()); end
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (max_val !== 20'hFFFFF) begin n_fail++; $display("FAIL max_hold_idle got %0h exp fffff", max_val); end
  endtask

  task automatic test_spurious_start();
    bit to;
    int errs;
    int done0;
    for (int i = 0; i < N; i++) mem[i] = 20'($urandom);
    ready_mode = 2;
    done0 = done_cnt;
    pulse_start();
    repeat (10) @(posedge clk);
    pulse_start();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL spur_busy got %0b exp 1", busy); end
    wait_done(6000, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL spur_done_timeout got timeout exp done"); end
    repeat (5) @(posedge clk);
    #1;
    errs = 0;
    for (int i = 0; i < N; i++)
      if (i >= got_q.size() || got_q[i] !== mem[i] || got_last_q[i] !== (i == N-1)) errs++;
    n_checks++; if (got_q.size() != N || errs != 0) begin n_fail++; $display("FAIL spur_sequence got %0d beats %0d bad exp %0d beats 0 bad", got_q.size(), errs, N); end
    n_checks++; if (done_cnt - done0 != 1) begin n_fail++; $display("FAIL spur_done_count got %0d exp 1", done_cnt - done0); end
  endtask

  task automatic test_reset_mid_run();
    bit to;
    bit hit;
    int errs;
    int seen_valid;
    for (int i = 0; i < N; i++) mem[i] = 20'($urandom);
    ready_mode = 1;
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (accepted >= 300) begin
        hit = 1'b1;
        break;
      end
    end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL rst_mid_reach got %0d beats exp 300", accepted); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if ({busy, crd, m_valid, m_last, done} !== 5'b0) begin n_fail++; $display("FAIL rst_mid_flags got %05b exp 00000", {busy, crd, m_valid, m_last, done}); end
    n_checks++; if (caddr_rd !== 12'd0 || csel !== 3'd0 || max_val !== 20'd0) begin n_fail++; $display("FAIL rst_mid_values got a=%0d s=%0d m=%0h exp 0 0 0", caddr_rd, csel, max_val); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_valid || busy || crd) seen_valid++;
    end
    n_checks++; if (seen_valid != 0) begin n_fail++; $display("FAIL rst_mid_quiet got %0d active cycles exp 0", seen_valid); end
    pulse_start();
    wait_done(3000, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL rst_mid_done_timeout got timeout exp done"); end
    errs = 0;
    for (int i = 0; i < N; i++)
      if (i >= got_q.size() || got_q[i] !== mem[i] || got_last_q[i] !== (i == N-1)) errs++;
    n_checks++; if (got_q.size() != N || errs != 0) begin n_fail++; $display("FAIL rst_mid_sequence got %0d beats %0d bad exp %0d beats 0 bad", got_q.size(), errs, N); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    test_reset();
    test_full_run();
    test_backpressure();
    test_stall();
    test_max();
    test_spurious_start();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flatten_streamer.md
FLATTEN_STREAMER -- requirements
Module: flatten_streamer

Interface
REQ-001 Parameter NUM_WORDS, default 1024: number of layer-1 words read and streamed per run.
REQ-002 Parameter FIFO_DEPTH, default 4: output FIFO entries, power of two, at least 2.
REQ-003 Parameter L1_SEL, default 3'b011: memory-select code for layer-1 (max-pool result) memory.
REQ-004 Clocking and reset: clock clk; reset reset, asynchronous, active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 start  in  1  single-cycle run request; honoured only in IDLE.
REQ-008 busy  out  1  high from the cycle after an accepted start until done.
REQ-009 crd  out  1  memory read strobe.
REQ-010 caddr_rd  out  12  memory read address.
REQ-011 csel  out  3  memory select; L1_SEL whenever crd=1, 3'b000 otherwise.
REQ-012 cdata_rd  in  20  read data, valid on the clock edge following the crd cycle.
REQ-013 m_valid / m_ready / m_data[19:0] / m_last  out/in/out/out  output stream; m_last marks word NUM_WORDS-1.
REQ-014 done  out  1  one-cycle pulse after the last stream beat is accepted.
REQ-015 max_val  out  20  unsigned maximum of all words streamed in the current or most recent run.

Function
REQ-016 FSM states: IDLE, READ, DRAIN, FINISH.
REQ-017 FSM transitions:
- IDLE->READ on start; address counter and beat counter clear, max_val clears to 0.
- READ->DRAIN the cycle after read NUM_WORDS-1 is issued.
- DRAIN->FINISH when the last beat handshakes (m_valid & m_ready & m_last).
- FINISH->IDLE unconditionally; done=1 in FINISH only.
REQ-018 Address order: caddr_rd = 0,1,...,NUM_WORDS-1, row-major, i.e. flatten order; each address is read exactly once.
REQ-019 Read issue: crd=1 in a READ cycle only if FIFO occupancy plus in-flight reads < FIFO_DEPTH; this credit rule guarantees no FIFO overflow.
REQ-020 In-flight tracking: at most one read in flight (1-cycle latency); returned data is written into the FIFO on the edge it is sampled.
REQ-021 Stream output: m_valid = FIFO not empty; m_data = FIFO head; a beat transfers when m_valid & m_ready.
REQ-022 Stream stability: m_data and m_last hold stable while m_valid=1 and m_ready=0.
REQ-023 Throughput: with m_ready held 1, one beat per cycle sustained after first-word latency.
REQ-024 Latency: first m_valid asserts exactly 3 cycles after the start cycle (IDLE->READ, read issue, FIFO write).
REQ-025 Simultaneous events: FIFO push and pop in the same cycle leave occupancy unchanged; pop of the last entry with a simultaneous push keeps m_valid=1.
REQ-026 m_last is derived from a beat counter, not from the address counter; it asserts with beat NUM_WORDS-1 only.
REQ-027 max_val updates on each transferred beat to max(max_val, m_data), unsigned 20-bit compare; it holds its value in IDLE.
REQ-028 start outside IDLE is ignored; no restart, no counter disturbance.
REQ-029 Backpressure: m_ready=0 indefinitely stalls reads once credits are exhausted; no data is lost or duplicated.
REQ-030 Counters: address and beat counters are sized to hold NUM_WORDS with no wrap within a run.

Reset
REQ-031 Reset is asynchronous, active-high, and effective mid-run; it clears all state.
REQ-032 Reset values: state=IDLE, busy=0, crd=0, caddr_rd=0, csel=0, m_valid=0, m_last=0, done=0, max_val=0; FIFO emptied, counters cleared.
REQ-033 After reset deasserts, the block waits for a fresh start.
REQ-034 Reset mid-run: in-flight read data arriving after reset is discarded.

Verification
REQ-035 Bench scenario, full run: memory[i]=i, m_ready=1, pulse start -> 1024 beats with data 0..1023 in order; m_last on beat 1023; done 1 cycle later; max_val=1023.
REQ-036 Bench scenario, random backpressure: m_ready random at 50% -> identical sequence, no gaps or duplicates; crd never asserts with occupancy+in-flight=4.
REQ-037 Bench scenario, stall: m_ready=0 from start -> exactly 4 reads issued, then crd=0; m_data=0 stable; release -> stream resumes at word 0.
REQ-038 Bench scenario, max tracking: memory all 0 except word 517=20'hFFFFF -> max_val=20'hFFFFF after done.
REQ-039 Bench scenario, reset mid-run: reset asserted at beat 300 -> all outputs at reset values immediately; new start -> beats again begin at 0.
REQ-040 Bench scenario, spurious start: start pulsed during READ -> ignored; run completes with exactly 1024 beats and one done pulse.
